// File: rtl/sipo_crypt_piso_stream.sv
// Serial-in / serial-out wrapper around an external block-cipher core.
// Assembles one block from lanes, launches the core, and streams the result back out.
module sipo_crypt_piso_stream #(
    parameter int DATA_W       = 128,
    parameter int LANE_W       = 1,
    parameter int MSB_FIRST    = 1,
    parameter int CORE_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [LANE_W-1:0] i_serial_in,
    input  logic              i_mode_in,
    output logic              o_in_ready,
    output logic              o_core_start,
    output logic              o_core_mode,
    output logic [DATA_W-1:0] o_core_data_out,
    input  logic              i_core_done,
    input  logic [DATA_W-1:0] i_core_data_in,
    output logic [LANE_W-1:0] o_serial_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int BEATS = DATA_W / LANE_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int TO_W  = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT + 1) : 1;

    generate
        if ((DATA_W % LANE_W) != 0) begin : g_bad_lane
            $fatal(1, "DATA_W must be a multiple of LANE_W");
        end
    endgenerate

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_in;
    logic [DATA_W-1:0] r_out;
    logic              r_mode;
    logic              r_timeout_err;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last_beat;
    logic              w_to_hit;
    logic [DATA_W-1:0] w_lane_ext;
    logic [DATA_W-1:0] w_shift_in;
    logic [DATA_W-1:0] w_shift_out;
    logic [LANE_W-1:0] w_head;

    assign w_in_fire   = (r_state == S_LOAD) && i_in_valid;
    assign w_out_fire  = (r_state == S_UNLOAD) && i_out_ready;
    assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
    assign w_to_hit    = (CORE_TIMEOUT > 0) && (r_to_cnt == TO_W'(CORE_TIMEOUT - 1));
    assign w_lane_ext  = DATA_W'(i_serial_in);

    // The first lane in ends up at the same end the first lane out is taken from.
    assign w_shift_in  = (MSB_FIRST != 0) ? ((r_in << LANE_W) | w_lane_ext)
                                          : ((r_in >> LANE_W) | (w_lane_ext << (DATA_W - LANE_W)));
    assign w_shift_out = (MSB_FIRST != 0) ? (r_out << LANE_W) : (r_out >> LANE_W);
    assign w_head      = (MSB_FIRST != 0) ? r_out[DATA_W-1 -: LANE_W] : r_out[LANE_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        o_in_ready      = 1'b0;
        o_core_start    = 1'b0;
        o_core_mode     = 1'b0;
        o_core_data_out = '0;
        o_serial_out    = '0;
        o_out_valid     = 1'b0;
        o_out_last      = 1'b0;
        o_busy          = 1'b0;
        o_timeout_err   = 1'b0;

        case (r_state)
            S_LOAD:   if (w_in_fire && w_last_beat) w_state_nxt = S_START;
            S_START:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_core_done) begin
                    w_state_nxt = S_UNLOAD;
                end else if (w_to_hit) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_UNLOAD: if (w_out_fire && w_last_beat) w_state_nxt = S_LOAD;
            default:  w_state_nxt = S_LOAD;
        endcase

        // Every output is forced low for as long as reset is held.
        if (!i_reset) begin
            o_in_ready      = (r_state == S_LOAD);
            o_core_start    = (r_state == S_START);
            o_core_mode     = r_mode;
            o_core_data_out = r_in;
            o_serial_out    = w_head;
            o_out_valid     = (r_state == S_UNLOAD);
            o_out_last      = (r_state == S_UNLOAD) && w_last_beat;
            o_busy          = (r_state != S_LOAD) || (r_cnt != '0);
            o_timeout_err   = r_timeout_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt         <= '0;
            r_to_cnt      <= '0;
            r_in          <= '0;
            r_out         <= '0;
            r_mode        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_in <= w_shift_in;
                        if (r_cnt == '0) r_mode <= i_mode_in;
                        r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (i_core_done) begin
                        r_out    <= i_core_data_in;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_timeout_err <= 1'b1;
                        r_to_cnt      <= '0;
                    end else if (CORE_TIMEOUT > 0) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (w_out_fire) begin
                        r_out <= w_shift_out;
                        r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
